comparator_nbit_serial: RTL and testbench

COMPARATOR_NBIT_SERIAL -- requirements
Module: comparator_nbit_serial

---
 rtl/comparator_pkg.sv | 16 +
 rtl/comparator_slice.sv | 22 ++
 rtl/comparator_nbit_serial.sv | 106 ++++++++++
 tb/tb_comparator_nbit_serial.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared constants and FSM encoding for the serial comparator.
// Result codes are one-hot; CMP_NONE marks "no slice has differed yet".
package comparator_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_LT   = 3'b010;
  localparam logic [2:0] CMP_EQ   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/comparator_slice.sv
// Combinational compare of one BPC-wide slice.
// Returns a one-hot gt/lt/eq code.
module comparator_slice
  import comparator_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] a_i,
  input  logic [BPC-1:0] b_i,
  output logic [2:0]     res_o
);

  always_comb begin
    res_o = CMP_EQ;
    unique case (1'b1)
      (a_i > b_i): res_o = CMP_GT;
      (a_i < b_i): res_o = CMP_LT;
      default:     res_o = CMP_EQ;
    endcase
  end

endmodule

// File: rtl/comparator_nbit_serial.sv
// MSB-first serial unsigned comparator, BITS_PER_CYCLE bits per cycle.
// Define COMPARATOR_EARLY_EXIT_EN to leave RUN on the first differing slice.
module comparator_nbit_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       y
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       dec_q, dec_d;
  logic [2:0]       y_q, y_d;
  logic [2:0]       slice_res;
  logic [2:0]       dec_nxt;
  logic             last;

  comparator_slice #(
    .BPC(BITS_PER_CYCLE)
  ) u_slice (
    .a_i  (a_q[WIDTH-1 -: BITS_PER_CYCLE]),
    .b_i  (b_q[WIDTH-1 -: BITS_PER_CYCLE]),
    .res_o(slice_res)
  );

  // Once decided, later slices cannot change the verdict.
  assign dec_nxt = (dec_q != CMP_NONE) ? dec_q :
                   (slice_res == CMP_EQ) ? CMP_NONE : slice_res;

`ifdef COMPARATOR_EARLY_EXIT_EN
  assign last = (cnt_q == LAST) || (dec_nxt != CMP_NONE);
`else
  assign last = (cnt_q == LAST);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          cnt_d   = '0;
          dec_d   = CMP_NONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q << BITS_PER_CYCLE;
        b_d   = b_q << BITS_PER_CYCLE;
        cnt_d = cnt_q + CW'(1);
        dec_d = dec_nxt;
        if (last) begin
          state_d = DONE;
          y_d     = (dec_nxt == CMP_NONE) ? CMP_EQ : dec_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= CMP_NONE;
      y_q     <= CMP_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign y    = y_q;

endmodule

// File: tb/tb_comparator_nbit_serial.sv
// Scoreboard bench for comparator_nbit_serial at BPC = 1, 4 and 2.
// Honours COMPARATOR_EARLY_EXIT_EN for expected latency.
module tb_comparator_nbit_serial;

  typedef struct {
    logic [2:0] y;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic       st1 = 1'b0, st4 = 1'b0, st2 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0, a2 = '0, b2 = '0;
  logic       bsy1, bsy4, bsy2, dn1, dn4, dn2;
  logic [2:0] y1, y4, y2;

  exp_t q1[$], q4[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comparator_nbit_serial #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
    .busy(bsy1), .done(dn1), .y(y1)
  );
  comparator_nbit_serial #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4),
    .busy(bsy4), .done(dn4), .y(y4)
  );
  comparator_nbit_serial #(.WIDTH(8), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2),
    .busy(bsy2), .done(dn2), .y(y2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // s = index of the edge that samples start.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input int bpc, input int s);
    exp_t e;
    int n;
    int lat;
    n   = 8 / bpc;
    lat = n;
    e.y = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
`ifdef COMPARATOR_EARLY_EXIT_EN
    for (int k = n - 1; k >= 0; k--) begin
      int sa, sb;
      sa = int'(a >> (8 - (k + 1) * bpc)) & ((1 << bpc) - 1);
      sb = int'(b >> (8 - (k + 1) * bpc)) & ((1 << bpc) - 1);
      if (sa != sb) lat = k + 1;
    end
`endif
    e.cyc = s + lat;
    return e;
  endfunction

  always @(negedge clk) begin
    if (dn1) begin
      chk("dut1_done_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_y", 64'(y1), 64'(e.y));
        chk("dut1_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (dn4) begin
      chk("dut4_done_expected", 64'(q4.size() != 0), 64'd1);
      if (q4.size() != 0) begin
        exp_t e;
        e = q4.pop_front();
        chk("dut4_y", 64'(y4), 64'(e.y));
        chk("dut4_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (dn2) begin
      chk("dut2_done_expected", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_y", 64'(y2), 64'(e.y));
        chk("dut2_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge of run cycle 1.
  task automatic start1(input logic [7:0] a, input logic [7:0] b,
                        input bit push);
    st1 = 1'b1;
    a1  = a;
    b1  = b;
    if (push) q1.push_back(model(a, b, 1, cyc + 1));
    @(negedge clk);
    st1 = 1'b0;
  endtask

  initial begin
    bit found;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'({bsy1, bsy4, bsy2}), 64'd0);
    chk("rst_done", 64'({dn1, dn4, dn2}), 64'd0);
    chk("rst_y", 64'({y1, y4, y2}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: 8 busy cycles, done in cycle 9.
    start1(8'hA5, 8'hA5, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("eq_busy_c%0d", k), 64'(bsy1), 64'd1);
      @(negedge clk);
    end
    chk("eq_busy_c9", 64'(bsy1), 64'd0);
    chk("eq_done_c9", 64'(dn1), 64'd1);
    @(negedge clk);
    chk("eq_done_c10", 64'(dn1), 64'd0);
    chk("eq_y_hold", 64'(y1), 64'd1);

    // MSB difference.
    start1(8'h80, 8'h7F, 1'b1);
    repeat (10) @(negedge clk);
    chk("msb_drain", 64'(q1.size()), 64'd0);

    // Multi-bit slices.
    st4 = 1'b1; a4 = 8'h00; b4 = 8'hFF;
    q4.push_back(model(8'h00, 8'hFF, 4, cyc + 1));
    @(negedge clk);
    st4 = 1'b0;
    st2 = 1'b1; a2 = 8'h12; b2 = 8'h13;
    q2.push_back(model(8'h12, 8'h13, 2, cyc + 1));
    @(negedge clk);
    st2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("bpc4_drain", 64'(q4.size()), 64'd0);
    chk("bpc2_drain", 64'(q2.size()), 64'd0);

    // Start in RUN with changed operands is ignored.
    start1(8'd1, 8'd2, 1'b1);
    @(negedge clk);
    st1 = 1'b1; a1 = 8'd9; b1 = 8'd3;
    @(negedge clk);
    st1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("ignore_drain", 64'(q1.size()), 64'd0);
    chk("ignore_y", 64'(y1), 64'b010);

    // Back-to-back: restart in the DONE cycle.
    start1(8'd5, 8'd3, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (dn1) found = 1'b1;
      else @(negedge clk);
    end
    chk("b2b_first_done", 64'(found), 64'd1);
    start1(8'd3, 8'd3, 1'b1);
    chk("b2b_no_gap_busy", 64'(bsy1), 64'd1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (dn1) found = 1'b1;
      else begin
        chk("b2b_y_hold", 64'(y1), 64'b100);
        @(negedge clk);
      end
    end
    chk("b2b_second_done", 64'(found), 64'd1);
    @(negedge clk);
    chk("b2b_drain", 64'(q1.size()), 64'd0);

    // Reset in run cycle 4 aborts without done.
    start1(8'h01, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_busy_c4", 64'(bsy1), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(bsy1), 64'd0);
    chk("abort_done", 64'(dn1), 64'd0);
    chk("abort_y", 64'(y1), 64'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_y_after", 64'(y1), 64'd0);
    chk("final_q1", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
